// File: rtl/ps2_key_event_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_key_event_queue_pkg
//  Brief    : Shared types and constants for the PS/2 key event queue:
//             decoder state encoding, event layout, prefix/drop bytes and
//             game direction codes.
//  Revision : 1.0 - initial release
// ============================================================================
package ps2_key_event_queue_pkg;

   // Decoder states; 3 bits cover the five prefix-folding states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_EXT    = 3'd1,
      ST_BRK    = 3'd2,
      ST_EXTBRK = 3'd3,
      ST_SKIP   = 3'd4
   } dec_state_t;

   // Event layout {ext, brk, code[7:0]}
   localparam int EV_W   = 10;
   localparam int EV_EXT = 9;
   localparam int EV_BRK = 8;

   // Prefix bytes
   localparam logic [7:0] c_pfx_e0 = 8'hE0;
   localparam logic [7:0] c_pfx_f0 = 8'hF0;
   localparam logic [7:0] c_pfx_e1 = 8'hE1;

   // Pause (E1 ...) is followed by seven more bytes that are swallowed
   localparam logic [2:0] c_skip_len = 3'd7;

   // Direction codes
   localparam logic [4:0] c_dir_none  = 5'b00000;
   localparam logic [4:0] c_dir_a     = 5'b00010;
   localparam logic [4:0] c_dir_b     = 5'b00100;
   localparam logic [4:0] c_dir_c     = 5'b01000;
   localparam logic [4:0] c_dir_d     = 5'b10000;
   localparam logic [4:0] c_dir_combo = 5'b00111;

   // Keyboard status/ack bytes that never form key events
   function automatic logic is_drop_byte(input logic [7:0] b);
      return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) ||
             (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
   endfunction

   // Map a released key code to its direction; unmapped codes keep prev
   function automatic logic [4:0] dir_next(input logic [7:0] code,
                                           input logic [4:0] prev);
      logic [4:0] r;
      r = prev;
      case (code)
         8'h75, 8'h1D: r = c_dir_a;
         8'h6B, 8'h1C: r = c_dir_b;
         8'h72, 8'h1B: r = c_dir_c;
         8'h74, 8'h23: r = c_dir_d;
         8'h29:        r = c_dir_combo;
         default:      r = prev;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_key_event_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_key_event_queue_if
//  Brief    : Byte input / event output bundle of the PS/2 key event queue.
//             master = byte source and processor read side, slave = queue.
//  Revision : 1.0 - initial release
// ============================================================================
interface ps2_key_event_queue_if
   import ps2_key_event_queue_pkg::*;
#(
   parameter int AW = 3
);
   logic [7:0]      byte_in;
   logic            byte_vld;
   logic            rd_en;
   logic            clr_ovf;
   logic            ev_valid;
   logic [EV_W-1:0] ev_data;
   logic [AW:0]     ev_count;
   logic            overflow;
   logic [4:0]      direcao;

   modport master (
      output byte_in, byte_vld, rd_en, clr_ovf,
      input  ev_valid, ev_data, ev_count, overflow, direcao
   );

   modport slave (
      input  byte_in, byte_vld, rd_en, clr_ovf,
      output ev_valid, ev_data, ev_count, overflow, direcao
   );
endinterface
`default_nettype wire

// File: rtl/ps2_key_event_queue_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Brief    : Single-clock FIFO with combinational head read. A pop on empty
//             is ignored; a push on full is accepted only with a pop.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             wr_en,
   input  wire logic [WIDTH-1:0] wr_data,
   input  wire logic             rd_en,
   output logic      [WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  empty,
   output logic      [AW:0]      count
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_wr;
   logic             w_rd;

   assign full    = (r_count == (AW+1)'(DEPTH));
   assign empty   = (r_count == '0);
   assign count   = r_count;
   assign rd_data = r_mem[r_rd_ptr];

   // Effective push/pop after full/empty qualification
   assign w_rd = rd_en && !empty;
   assign w_wr = wr_en && (!full || rd_en);

   // Pointer and occupancy tracking; pointers wrap naturally at 2**AW
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage array; contents need no reset
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= wr_data;
   end
endmodule
`default_nettype wire

// File: rtl/ps2_key_event_queue.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_key_event_queue
//  Brief    : Folds PS/2 scan-code prefixes (E0/F0/E1) into key events,
//             queues them for the processor and tracks the game direction
//             code of the last released mapped key.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_key_event_queue
   import ps2_key_event_queue_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input wire logic               clk,
   input wire logic               rst_n,
   ps2_key_event_queue_if.slave   bus
);
   dec_state_t      r_state;
   logic [2:0]      r_skip_cnt;
   logic [4:0]      r_dir;
   logic            r_overflow;
   logic            w_emit;
   logic [EV_W-1:0] w_ev;
   logic            w_full;
   logic            w_empty;
   logic [AW:0]     w_count;
   logic [EV_W-1:0] w_head;

   // Decide whether the current byte completes an event and build it
   always_comb begin
      w_emit = 1'b0;
      w_ev   = '0;
      if (bus.byte_vld) begin
         case (r_state)
            ST_IDLE: begin
               if (bus.byte_in != c_pfx_e0 && bus.byte_in != c_pfx_f0 &&
                   bus.byte_in != c_pfx_e1 && !is_drop_byte(bus.byte_in)) begin
                  w_emit = 1'b1;
                  w_ev   = {1'b0, 1'b0, bus.byte_in};
               end
            end
            ST_EXT: begin
               if (bus.byte_in != c_pfx_f0 && bus.byte_in != c_pfx_e0) begin
                  w_emit = 1'b1;
                  w_ev   = {1'b1, 1'b0, bus.byte_in};
               end
            end
            ST_BRK: begin
               if (bus.byte_in != c_pfx_f0) begin
                  w_emit = 1'b1;
                  w_ev   = {1'b0, 1'b1, bus.byte_in};
               end
            end
            ST_EXTBRK: begin
               w_emit = 1'b1;
               w_ev   = {1'b1, 1'b1, bus.byte_in};
            end
            default: begin
               w_emit = 1'b0;
            end
         endcase
      end
   end

   // Prefix decoder FSM with Pause-sequence skip counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_skip_cnt <= '0;
      end else if (bus.byte_vld) begin
         case (r_state)
            ST_IDLE: begin
               if (bus.byte_in == c_pfx_e0) begin
                  r_state <= ST_EXT;
               end else if (bus.byte_in == c_pfx_f0) begin
                  r_state <= ST_BRK;
               end else if (bus.byte_in == c_pfx_e1) begin
                  r_state    <= ST_SKIP;
                  r_skip_cnt <= c_skip_len;
               end
            end
            ST_EXT: begin
               if (bus.byte_in == c_pfx_f0)      r_state <= ST_EXTBRK;
               else if (bus.byte_in != c_pfx_e0) r_state <= ST_IDLE;
            end
            ST_BRK: begin
               if (bus.byte_in != c_pfx_f0) r_state <= ST_IDLE;
            end
            ST_EXTBRK: begin
               r_state <= ST_IDLE;
            end
            ST_SKIP: begin
               r_skip_cnt <= r_skip_cnt - 3'd1;
               // A zero count would be stale; leave instead of wrapping
               if (r_skip_cnt <= 3'd1) r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Direction code follows every break event, even one the FIFO drops
   always_ff @(posedge clk) begin
      if (!rst_n)                        r_dir <= c_dir_none;
      else if (w_emit && w_ev[EV_BRK])   r_dir <= dir_next(w_ev[7:0], r_dir);
   end

   // Sticky overflow; a drop in the same cycle as a clear keeps it set
   always_ff @(posedge clk) begin
      if (!rst_n)                               r_overflow <= 1'b0;
      else if (w_emit && w_full && !bus.rd_en)  r_overflow <= 1'b1;
      else if (bus.clr_ovf)                     r_overflow <= 1'b0;
   end

   sync_fifo #(
      .WIDTH (EV_W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (w_emit),
      .wr_data (w_ev),
      .rd_en   (bus.rd_en),
      .rd_data (w_head),
      .full    (w_full),
      .empty   (w_empty),
      .count   (w_count)
   );

   assign bus.ev_valid = !w_empty;
   assign bus.ev_data  = w_head;
   assign bus.ev_count = w_count;
   assign bus.overflow = r_overflow;
   assign bus.direcao  = r_dir;
endmodule
`default_nettype wire
